icache_ro: RTL and testbench
============================

ICACHE_RO -- requirements
Module: icache_ro

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, number of direct-mapped lines (power of two, 2..64).
REQ-002 SHALL have parameter LINE_WORDS, fixed 4, 32-bit words per line (128-bit line).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port proc_ren  input  1  fetch request.
REQ-006 SHALL have port proc_wen  input  1  write request; always ignored.
REQ-007 SHALL have port proc_addr  input  32  byte address from fetch stage; bits [1:0] ignored.
REQ-008 SHALL have port proc_wdata  input  32  ignored.
REQ-009 SHALL have port proc_rdata  output  32  instruction word.
REQ-010 SHALL have port proc_stall  output  1  fetch must hold its PC.
REQ-011 SHALL have port mem_read  output  1  line-fill request.
REQ-012 SHALL have port mem_write  output  1  tied 0.
REQ-013 SHALL have port mem_addr  output  28  line address, equal to proc_addr[31:4].
REQ-014 SHALL have port mem_wdata  output  128  tied 0.
REQ-015 SHALL have port mem_rdata  input  128  fill data; word k in bits [32k+31:32k].
REQ-016 SHALL have port mem_ready  input  1  fill data valid this cycle.

Function
REQ-017 SHALL split proc_addr as follows: offset = [3:2]; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
REQ-018 SHALL implement a two-state FSM with states IDLE and FILL.
REQ-019 SHALL detect a hit in IDLE when proc_ren=1, valid[index]=1, and tag matches; the hit is combinational in the same cycle.
REQ-020 SHALL, on a hit, drive proc_stall=0 and proc_rdata to the selected word in the same cycle (0-cycle hit latency).
REQ-021 SHALL, on a miss in IDLE with proc_ren=1, drive proc_stall=1 in the same cycle, latch miss line address into mem_addr, and move to FILL.
REQ-022 SHALL drive mem_read and mem_addr as registered outputs; mem_read=1 starting the cycle after miss detection and holding through the mem_ready cycle.
REQ-023 SHALL, in FILL, hold proc_stall=1 and keep mem_addr constant even if proc_addr changes.
REQ-024 SHALL, in FILL with mem_ready=1, write mem_rdata into the line at the latched index, set tag and valid, deassert mem_read on the next edge, and return to IDLE.
REQ-025 SHALL re-evaluate current proc_addr in the IDLE cycle following a fill; a hit there gives proc_stall=0 (miss-to-data = fill cycles + 1).
REQ-026 SHALL, with proc_ren=0 in IDLE, drive proc_stall=0 and make no state change.
REQ-027 SHALL ignore mem_ready while in IDLE.
REQ-028 SHALL treat proc_wen=1 as a no-op: no array change and no stall contribution.
REQ-029 SHALL drive proc_rdata to 0 whenever proc_stall=1.
REQ-030 SHALL, on a fill replacing a valid line with a different tag, overwrite it (no writeback).

Reset
REQ-031 SHALL, on rst_n=0, immediately clear all valid bits, set state=IDLE, mem_read=0, mem_addr=0.
REQ-032 SHALL drive proc_stall=1 in the first cycle after reset when proc_ren=1, because all lines are invalid.
REQ-033 SHALL, on reset during FILL, abandon the fill; a mem_ready arriving afterward is ignored.
REQ-034 SHALL not reset data and tag arrays.

Structure
REQ-035 SHALL place line width (128), word width, offset/index/tag widths, and FSM state encodings in the shared core package.
REQ-036 SHALL use one sub-module, icache_array, holding tag, valid, and data storage with one read port and one line-write port.

Verification
REQ-037 SHALL verify: after reset, proc_ren=1, addr 0x00000000 -> stall=1; mem_read=1, mem_addr=0x0000000 next cycle; mem_ready with line {0x…13,0x…,0x…,0x00000013} -> stall=0 one cycle later, rdata=word0.
REQ-038 SHALL verify: after the fill of line 0, addresses 0x4, 0x8, 0xC -> stall=0 each cycle and rdata = words 1, 2, 3.
REQ-039 SHALL verify: with NUM_LINES=8, 0x00000000 then 0x00000080 (same index, different tag) -> miss, mem_addr=0x0000008; refetch 0x0 -> miss again.
REQ-040 SHALL verify: during FILL, proc_addr changed to 0x40 -> mem_addr stays 0x0000000; after the fill, 0x40 misses with mem_addr=0x0000004.
REQ-041 SHALL verify: rst_n pulsed low during FILL, then mem_ready=1 -> no line valid, mem_read=0, next fetch of the same address misses.
REQ-042 SHALL verify: proc_wen=1 with proc_wdata=0xDEADBEEF on a cached address -> a subsequent read returns the original word with stall=0.

Source files
------------

// File: rtl/icache_ro_pkg.sv
// Shared widths and FSM encoding for the read-only direct-mapped instruction cache.
package icache_ro_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int LINE_WORDS  = 4;
  localparam int LINE_W      = WORD_W * LINE_WORDS;
  localparam int BYTE_OFF_W  = 2;
  localparam int OFFSET_W    = 2;
  localparam int LINE_ADDR_W = ADDR_W - BYTE_OFF_W - OFFSET_W;

  // Index/tag widths depend on the line count chosen at instantiation.
  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int num_lines);
    return LINE_ADDR_W - $clog2(num_lines);
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: one combinational read port, one full-line write port.
module icache_array
  import icache_ro_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_line_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_ro.sv
// Read-only direct-mapped instruction cache: 0-cycle hits, blocking single-line fills.
module icache_ro
  import icache_ro_pkg::*;
#(
  parameter int NUM_LINES  = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   proc_ren,
  input  logic                   proc_wen,
  input  logic [ADDR_W-1:0]      proc_addr,
  input  logic [WORD_W-1:0]      proc_wdata,
  output logic [WORD_W-1:0]      proc_rdata,
  output logic                   proc_stall,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [LINE_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic [LINE_W-1:0]      mem_rdata,
  input  logic                   mem_ready
);

  localparam int IDX_W  = index_w(NUM_LINES);
  localparam int TAG_W  = tag_w(NUM_LINES);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_LO = BYTE_OFF_W + OFF_W;

  state_e                 state_q;
  logic                   mem_read_q;
  logic [LINE_ADDR_W-1:0] mem_addr_q;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              hit;
  logic              miss;
  logic              fill_en;

  assign req_off = proc_addr[BYTE_OFF_W +: OFF_W];
  assign req_idx = proc_addr[IDX_LO +: IDX_W];
  assign req_tag = proc_addr[ADDR_W-1 -: TAG_W];

  // Writes, write data and byte-offset bits have no effect on a read-only cache.
  logic unused_ok;
  assign unused_ok = ^{proc_wen, proc_wdata, proc_addr[BYTE_OFF_W-1:0]};

  assign hit     = (state_q == ST_IDLE) && proc_ren && rd_valid && (rd_tag == req_tag);
  assign miss    = (state_q == ST_IDLE) && proc_ren && !hit;
  assign fill_en = (state_q == ST_FILL) && mem_ready;

  icache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_en_i    (fill_en),
    .wr_idx_i   (mem_addr_q[IDX_W-1:0]),
    .wr_tag_i   (mem_addr_q[LINE_ADDR_W-1:IDX_W]),
    .wr_line_i  (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss) begin
            state_q    <= ST_FILL;
            mem_read_q <= 1'b1;
            mem_addr_q <= proc_addr[ADDR_W-1:IDX_LO];
          end
        end
        ST_FILL: begin
          if (mem_ready) begin
            state_q    <= ST_IDLE;
            mem_read_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

  assign proc_stall = (state_q == ST_FILL) || miss;
  assign proc_rdata = hit ? rd_line[req_off*WORD_W +: WORD_W] : '0;
  assign mem_read   = mem_read_q;
  assign mem_addr   = mem_addr_q;
  assign mem_write  = 1'b0;
  assign mem_wdata  = '0;

endmodule

// File: tb/tb_icache_ro.sv
// Directed bench for icache_ro: table of hit/no-op vectors plus hand-written miss/fill sequences.
module tb_icache_ro;

  logic         clk;
  logic         rst_n;
  logic         proc_ren;
  logic         proc_wen;
  logic [31:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] LINE_A = {32'h00300193, 32'h00200113, 32'h00100093, 32'h00000013};
  localparam logic [127:0] LINE_B = {32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001, 32'hBBBB0000};
  localparam logic [127:0] LINE_C = {32'hCCCC0003, 32'hCCCC0002, 32'hCCCC0001, 32'hCCCC0000};
  localparam logic [127:0] JUNK   = {4{32'hFFFF_FFFF}};

  icache_ro #(.NUM_LINES(8), .LINE_WORDS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_ren   (proc_ren),
    .proc_wen   (proc_wen),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mrdy;
    logic        exp_stall;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] line, input logic [31:0] addr);
    logic [127:0] l;
    l = line;
    return l[addr[3:2]*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    proc_ren   = 1'b0;
    proc_wen   = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset mem_read", mem_read, 1'b0);
    check("reset mem_addr", mem_addr, 28'h0);
    check("reset stall idle", proc_stall, 1'b0);
    check("reset mem_write", mem_write, 1'b0);
    check("reset mem_wdata", mem_wdata, 128'h0);
    tick();
    rst_n = 1'b1;
  endtask

  // Miss on addr, fill with line in the first FILL cycle, expect the hit one cycle later.
  task automatic fetch_miss(input string tag, input logic [31:0] addr, input logic [127:0] line,
                            input logic [27:0] exp_maddr);
    proc_ren  = 1'b1;
    proc_addr = addr;
    @(negedge clk);
    check({tag, " miss stall"}, proc_stall, 1'b1);
    check({tag, " miss rdata"}, proc_rdata, 32'h0);
    check({tag, " miss mem_read"}, mem_read, 1'b0);
    tick();
    @(negedge clk);
    check({tag, " fill mem_read"}, mem_read, 1'b1);
    check({tag, " fill mem_addr"}, mem_addr, exp_maddr);
    mem_ready = 1'b1;
    mem_rdata = line;
    #1;
    check({tag, " fill stall"}, proc_stall, 1'b1);
    check({tag, " fill rdata"}, proc_rdata, 32'h0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check({tag, " post mem_read"}, mem_read, 1'b0);
    check({tag, " post stall"}, proc_stall, 1'b0);
    check({tag, " post rdata"}, proc_rdata, word_of(line, addr));
    tick();
    proc_ren = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00100093};
    vecs[1] = '{1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00200113};
    vecs[2] = '{1'b1, 1'b0, 32'h0C, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00300193};
    vecs[3] = '{1'b1, 1'b0, 32'h03, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00000013};
    vecs[4] = '{1'b1, 1'b0, 32'h0E, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00300193};
    vecs[5] = '{1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 32'h04, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00100093};
    vecs[8] = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[9] = '{1'b1, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00000013};

    rst_n = 1'b0;
    clear_inputs();
    do_reset();

    // First fetch after reset misses, fills line 0, then hits.
    fetch_miss("cold", 32'h0000_0000, LINE_A, 28'h0);

    // Hits across line 0, write no-op, and mem_ready in IDLE.
    for (int i = 0; i < 10; i++) begin
      proc_ren   = vecs[i].ren;
      proc_wen   = vecs[i].wen;
      proc_addr  = vecs[i].addr;
      proc_wdata = vecs[i].wdata;
      mem_ready  = vecs[i].mrdy;
      mem_rdata  = vecs[i].mrdy ? JUNK : '0;
      @(negedge clk);
      check($sformatf("vec%0d stall", i), proc_stall, vecs[i].exp_stall);
      check($sformatf("vec%0d mem_read", i), mem_read, 1'b0);
      if (vecs[i].chk_rdata) check($sformatf("vec%0d rdata", i), proc_rdata, vecs[i].exp_rdata);
      tick();
    end
    clear_inputs();

    // Conflict: same index, different tag, then back again.
    fetch_miss("conflict", 32'h0000_0080, LINE_B, 28'h8);
    fetch_miss("refetch", 32'h0000_0000, LINE_A, 28'h0);

    // proc_addr moves during FILL: mem_addr must hold.
    do_reset();
    proc_ren  = 1'b1;
    proc_addr = 32'h0;
    @(negedge clk);
    check("move miss stall", proc_stall, 1'b1);
    tick();
    @(negedge clk);
    check("move mem_read", mem_read, 1'b1);
    check("move mem_addr", mem_addr, 28'h0);
    proc_addr = 32'h40;
    tick();
    @(negedge clk);
    check("move hold mem_addr", mem_addr, 28'h0);
    check("move hold mem_read", mem_read, 1'b1);
    check("move hold stall", proc_stall, 1'b1);
    check("move hold rdata", proc_rdata, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = LINE_A;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check("move 0x40 miss stall", proc_stall, 1'b1);
    check("move mem_read low", mem_read, 1'b0);
    tick();
    @(negedge clk);
    check("move 0x40 mem_read", mem_read, 1'b1);
    check("move 0x40 mem_addr", mem_addr, 28'h4);
    mem_ready = 1'b1;
    mem_rdata = LINE_C;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check("move 0x40 hit stall", proc_stall, 1'b0);
    check("move 0x40 hit rdata", proc_rdata, 32'hCCCC0000);
    proc_addr = 32'h0;
    #1;
    check("move 0x0 hit stall", proc_stall, 1'b0);
    check("move 0x0 hit rdata", proc_rdata, 32'h00000013);
    tick();

    // Reset during FILL abandons the fill; late mem_ready is ignored.
    proc_addr = 32'h20;
    @(negedge clk);
    check("abort miss stall", proc_stall, 1'b1);
    tick();
    @(negedge clk);
    check("abort mem_read", mem_read, 1'b1);
    check("abort mem_addr", mem_addr, 28'h2);
    rst_n = 1'b0;
    #1;
    check("abort rst mem_read", mem_read, 1'b0);
    check("abort rst mem_addr", mem_addr, 28'h0);
    check("abort rst stall", proc_stall, 1'b1);
    proc_ren = 1'b0;
    tick();
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = LINE_B;
    @(negedge clk);
    check("abort late mem_read", mem_read, 1'b0);
    check("abort late stall", proc_stall, 1'b0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check("abort idle mem_read", mem_read, 1'b0);
    proc_ren  = 1'b1;
    proc_addr = 32'h0;
    #1;
    check("abort 0x0 invalid stall", proc_stall, 1'b1);
    proc_addr = 32'h20;
    #1;
    check("abort 0x20 miss stall", proc_stall, 1'b1);
    check("abort 0x20 rdata", proc_rdata, 32'h0);
    tick();
    @(negedge clk);
    check("abort refill mem_read", mem_read, 1'b1);
    check("abort refill mem_addr", mem_addr, 28'h2);
    mem_ready = 1'b1;
    mem_rdata = LINE_B;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check("abort refill stall", proc_stall, 1'b0);
    check("abort refill rdata", proc_rdata, 32'hBBBB0000);
    tick();
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
